// File: rtl/prog_loader_pkg.sv
// Shared constants and loader state encoding for the instruction-memory loader.
// Memory geometry is shared with the pipeline's instr_mem declaration.
package prog_loader_pkg;

  localparam int IMEM_DEPTH = 16;
  localparam int IMEM_AW    = 4;
  localparam int INSTR_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    CSUM,
    DONE,
    ERR
  } ld_state_t;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream loader: assembles big-endian words into instr_mem, verifies an
// XOR checksum and releases the pipeline hold only on a good image.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW,
  parameter int IW    = INSTR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [IW-1:0] mem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  localparam logic [7:0] MAX_LEN = 8'(DEPTH);

  ld_state_t     state, state_n;
  logic [AW-1:0] last, last_n;
  logic [AW-1:0] idx, idx_n;
  logic [7:0]    hi, hi_n;
  logic [7:0]    csum, csum_n;
  logic          we_n, hold_n, done_n, err_n;
  logic [AW-1:0] addr_n;
  logic [IW-1:0] wdata_n;
  logic [AW:0]   wl_n;
  logic          acc;

  assign in_ready = (state == LEN) || (state == HI) ||
                    (state == LO)  || (state == CSUM);
  assign acc = in_valid && in_ready;

  always_comb begin
    state_n = state;
    last_n  = last;
    idx_n   = idx;
    hi_n    = hi;
    csum_n  = csum;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    hold_n  = cpu_hold;
    done_n  = done;
    err_n   = error;
    wl_n    = words_loaded;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n = LEN;
          wl_n    = '0;
          done_n  = 1'b0;
          err_n   = 1'b0;
          csum_n  = '0;
          hold_n  = 1'b1;
        end
      end
      LEN: begin
        if (acc) begin
          if (in_data == 8'd0 || in_data > MAX_LEN) begin
            state_n = ERR;
            err_n   = 1'b1;
            hold_n  = 1'b1;
          end else begin
            last_n  = AW'(in_data - 8'd1);
            idx_n   = '0;
            state_n = HI;
          end
        end
      end
      HI: begin
        if (acc) begin
          hi_n    = in_data;
          csum_n  = csum ^ in_data;
          state_n = LO;
        end
      end
      LO: begin
        if (acc) begin
          csum_n  = csum ^ in_data;
          we_n    = 1'b1;
          addr_n  = idx;
          wdata_n = {hi, in_data};
          wl_n    = words_loaded + 1'b1;
          if (idx == last) begin
            state_n = CSUM;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = HI;
          end
        end
      end
      CSUM: begin
        if (acc) begin
          if (in_data == csum) begin
            state_n = DONE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end else begin
            state_n = ERR;
            err_n   = 1'b1;
            hold_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last         <= '0;
      idx          <= '0;
      hi           <= '0;
      csum         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state        <= state_n;
      last         <= last_n;
      idx          <= idx_n;
      hi           <= hi_n;
      csum         <= csum_n;
      mem_we       <= we_n;
      mem_addr     <= addr_n;
      mem_wdata    <= wdata_n;
      cpu_hold     <= hold_n;
      done         <= done_n;
      error        <= err_n;
      words_loaded <= wl_n;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frames are scored against a
// frame-level model of the expected memory image and final status.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [4:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame[$];
  logic [15:0] exp_w[$];
  logic [3:0]  wa[$];
  logic [15:0] wd[$];

  prog_loader dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (done === 1'b1 && error === 1'b1) begin
      errors++;
      $display("FAIL done_error_both done=%b error=%b required not both", done, error);
    end
  end

  // Frame-level model: expected words, outcome, and bytes the DUT consumes.
  task automatic model(output bit ok, output int nb);
    int len;
    logic [7:0] x;
    len = int'(frame[0]);
    exp_w.delete();
    ok = 1'b0;
    x = 8'h00;
    if (len < 1 || len > 16) begin
      nb = 1;
      return;
    end
    nb = 2 * len + 2;
    for (int i = 0; i < len; i++) begin
      exp_w.push_back({frame[1 + 2 * i], frame[2 + 2 * i]});
      x = x ^ frame[1 + 2 * i] ^ frame[2 + 2 * i];
    end
    ok = (frame[2 * len + 1] == x);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int t;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    in_valid = 1'b0;
    repeat (g) @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL byte_timeout in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic build_random(input int len, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    frame.delete();
    frame.push_back(8'(len));
    x = 8'h00;
    if (len >= 1 && len <= 16) begin
      for (int i = 0; i < 2 * len; i++) begin
        b = 8'($urandom_range(0, 255));
        frame.push_back(b);
        x = x ^ b;
      end
      if (corrupt) x = x ^ 8'($urandom_range(1, 255));
      frame.push_back(x);
    end
  endtask

  task automatic test_frame(input string name, input int maxgap, input bit do_start);
    bit ok;
    int nb;
    model(ok, nb);
    wa.delete();
    wd.delete();
    if (do_start) pulse_start();
    for (int i = 0; i < nb; i++) send_byte(frame[i], maxgap);
    repeat (2) @(negedge clk);
    checks++;
    if (done !== ok || error !== !ok || cpu_hold !== !ok) begin
      errors++;
      $display("FAIL %s_status done=%b error=%b hold=%b required %b %b %b",
               name, done, error, cpu_hold, ok, !ok, !ok);
    end
    checks++;
    if (words_loaded !== 5'(exp_w.size())) begin
      errors++;
      $display("FAIL %s_words_loaded got %0d required %0d", name, words_loaded, exp_w.size());
    end
    checks++;
    if (wa.size() != exp_w.size()) begin
      errors++;
      $display("FAIL %s_write_count got %0d required %0d", name, wa.size(), exp_w.size());
    end else begin
      for (int i = 0; i < exp_w.size(); i++) begin
        checks++;
        if (wa[i] !== 4'(i) || wd[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL %s_write%0d got %h:%h required %h:%h",
                   name, i, wa[i], wd[i], 4'(i), exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 4'h0 ||
        mem_wdata !== 16'h0 || cpu_hold !== 1'b1 || done !== 1'b0 ||
        error !== 1'b0 || words_loaded !== 5'd0) begin
      errors++;
      $display("FAIL reset_values rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b wl=%0d required 0 0 0 0 1 0 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_loaded);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    frame = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    test_frame("basic", 0, 1'b1);
  endtask

  task automatic test_bad_csum();
    frame = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    test_frame("bad_csum", 0, 1'b1);
  endtask

  task automatic test_bad_len();
    frame = '{8'h00};
    test_frame("len_zero", 0, 1'b1);
    frame = '{8'h11};
    test_frame("len_17", 0, 1'b1);
  endtask

  task automatic test_full_depth();
    build_random(16, 1'b0);
    test_frame("full_depth", 3, 1'b1);
  endtask

  task automatic test_start_ignored_and_reset();
    frame = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF};
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(frame[0], 0);
    pulse_start();
    for (int i = 1; i < 6; i++) send_byte(frame[i], 1);
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || wa.size() != 2) begin
      errors++;
      $display("FAIL start_ignored done=%b error=%b writes=%0d required 1 0 2",
               done, error, wa.size());
    end
    frame = '{8'h03, 8'h11, 8'h22, 8'h33};
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(frame[i], 0);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 4'h0 ||
        mem_wdata !== 16'h0 || cpu_hold !== 1'b1 || done !== 1'b0 ||
        error !== 1'b0 || words_loaded !== 5'd0) begin
      errors++;
      $display("FAIL midload_reset rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b wl=%0d required 0 0 0 0 1 0 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_loaded);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    build_random(5, 1'b0);
    test_frame("after_reset", 2, 1'b1);
  endtask

  task automatic test_reload();
    frame = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03};
    test_frame("pre_reload", 0, 1'b1);
    pulse_start();
    checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== 5'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_start done=%b hold=%b wl=%0d rdy=%b required 0 1 0 1",
               done, cpu_hold, words_loaded, in_ready);
    end
    frame = '{8'h01, 8'hAB, 8'hCD, 8'h66};
    test_frame("reload", 0, 1'b0);
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 10; k++) begin
      len = int'($urandom_range(0, 19));
      build_random(len, ($urandom_range(0, 3) == 0));
      test_frame($sformatf("rand%0d", k), 2, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_bad_len();
    test_full_depth();
    test_start_ignored_and_reset();
    test_reload();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
